keypad_entry_16b: RTL

- Front-end input block for the adder/subtractor board.
- Scans a 4x4 hex matrix keypad, debounces key presses, and shifts accepted hex digits into a 16-bit operand register.
- X and NEG connect directly to the x and neg inputs of display_16bto4h, so keypad entry is echoed on the 4-digit seven-segment display.
- It is the input end of the same operand path that the display drives out.

---
 rtl/keypad_entry_16b.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/keypad_entry_16b.sv
// keypad_entry_16b: 4x4 hex keypad scanner with debounce and a 16-bit
// shift-in operand register that feeds the display's x/neg inputs.
// Optional feature macro: KEYPAD_SIGN_EN (SIGN pulse toggles NEG[3]).
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | walking rows one per tick, waiting for a single-column press
// DEBOUNCE | row frozen, counting identical samples of the captured key
// HOLD     | key accepted, row frozen, counting all-high release samples
module keypad_entry_16b #(
   parameter int SCAN_DIV   = 1,
   parameter int DEBOUNCE_N = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  COL,
   output logic [3:0]  ROW,
   input  logic        CLR,
   input  logic        SIGN,
   output logic [3:0]  KEY,
   output logic        KEY_VALID,
   output logic [15:0] X,
   output logic [3:0]  NEG
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_N + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_N);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD} state_t;

   state_t           state, state_n;
   logic [1:0]       row_idx, row_n;
   logic [DIV_W-1:0] div_cnt, div_n;
   logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
   logic [3:0]       code, code_n;
   logic [3:0]       key_n;
   logic             kv_n;
   logic [15:0]      x_n;
   logic [3:0]       neg_n;
   logic             tick, col_ok, accept;
   logic [1:0]       col_idx;

`ifndef KEYPAD_SIGN_EN
   logic             unused_sign;
   assign unused_sign = SIGN;
`endif

   assign tick    = (div_cnt == DIV_LAST);
   assign cnt_inc = cnt + 1'b1;
   assign ROW     = ~(4'b0001 << row_idx);

   // Decode a valid sample: exactly one column pulled low.
   always_comb begin
      col_ok  = 1'b0;
      col_idx = 2'd0;
      case (COL)
         4'b1110: begin col_ok = 1'b1; col_idx = 2'd0; end
         4'b1101: begin col_ok = 1'b1; col_idx = 2'd1; end
         4'b1011: begin col_ok = 1'b1; col_idx = 2'd2; end
         4'b0111: begin col_ok = 1'b1; col_idx = 2'd3; end
         default: begin col_ok = 1'b0; col_idx = 2'd0; end
      endcase
   end

   // Next-state, scan, debounce and operand-register logic.
   always_comb begin
      state_n = state;
      row_n   = row_idx;
      div_n   = tick ? '0 : div_cnt + 1'b1;
      cnt_n   = cnt;
      code_n  = code;
      key_n   = KEY;
      kv_n    = 1'b0;
      x_n     = X;
      neg_n   = NEG;
      accept  = 1'b0;

      if (tick) begin
         case (state)
            IDLE: begin
               if (col_ok) begin
                  code_n = {row_idx, col_idx};
                  if (CNT_DONE == CNT_W'(1)) begin
                     accept  = 1'b1;
                     cnt_n   = '0;
                     state_n = HOLD;
                  end else begin
                     cnt_n   = CNT_W'(1);
                     state_n = DEBOUNCE;
                  end
               end else begin
                  row_n = row_idx + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (col_ok && col_idx == code[1:0]) begin
                  if (cnt_inc == CNT_DONE) begin
                     accept  = 1'b1;
                     cnt_n   = '0;
                     state_n = HOLD;
                  end else begin
                     cnt_n = cnt_inc;
                  end
               end else begin
                  // bounce: drop the candidate and carry on with the next row
                  cnt_n   = '0;
                  row_n   = row_idx + 2'd1;
                  state_n = IDLE;
               end
            end
            HOLD: begin
               if (COL == 4'hF) begin
                  if (cnt_inc == CNT_DONE) begin
                     cnt_n   = '0;
                     state_n = IDLE;
                  end else begin
                     cnt_n = cnt_inc;
                  end
               end else begin
                  cnt_n = '0;
               end
            end
            default: begin
               cnt_n   = '0;
               state_n = IDLE;
            end
         endcase
      end

      if (accept) begin
         key_n = code_n;
         kv_n  = 1'b1;
         x_n   = {X[11:0], code_n};
      end

`ifdef KEYPAD_SIGN_EN
      neg_n = {NEG[3] ^ SIGN, 3'b000};
`else
      neg_n = 4'b0000;
`endif

      // clear beats a same-cycle acceptance; KEY/KEY_VALID still report it
      if (CLR) begin
         x_n   = '0;
         neg_n = 4'b0000;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         row_idx   <= 2'd0;
         div_cnt   <= '0;
         cnt       <= '0;
         code      <= 4'h0;
         KEY       <= 4'h0;
         KEY_VALID <= 1'b0;
         X         <= 16'h0000;
         NEG       <= 4'b0000;
      end else begin
         state     <= state_n;
         row_idx   <= row_n;
         div_cnt   <= div_n;
         cnt       <= cnt_n;
         code      <= code_n;
         KEY       <= key_n;
         KEY_VALID <= kv_n;
         X         <= x_n;
         NEG       <= neg_n;
      end
   end

endmodule
